// File: rtl/algorithm_result_sink_pkg.sv
// ============================================================================
// Module : algorithm_result_sink_pkg
// Brief  : Shared types and widths for the algorithm result sink.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package algorithm_result_sink_pkg;

   // Codebase default integer width, used as the result data width default.
   localparam int INT_W = 8;

   // Two states in a 2-bit encoding; the two spare codes recover to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01
   } state_t;

endpackage : algorithm_result_sink_pkg

`default_nettype wire

// File: rtl/algorithm_result_sink_sat_counter.sv
// ============================================================================
// Module : algorithm_result_sink_sat_counter
// Brief  : Saturating up-counter with synchronous clear; holds at all-ones.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module algorithm_result_sink_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   // Clear has priority over increment; increment stops at all-ones.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc && (value_q != {W{1'b1}})) begin
         value_d = value_q + 1'b1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule : algorithm_result_sink_sat_counter

`default_nettype wire

// File: rtl/algorithm_result_sink.sv
// ============================================================================
// Module : algorithm_result_sink
// Brief  : Receiving end of the algorithm handshake. Captures each result,
//          measures request-to-result latency, counts completions and
//          presents everything as registered status.
//          Optional macro RESULT_TIMEOUT_EN adds a WAIT-state abort after
//          TIMEOUT cycles with a sticky timeout flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module algorithm_result_sink
   import algorithm_result_sink_pkg::*;
#(
   parameter int WIDTH = INT_W,
   parameter int LAT_W = 8,
   parameter int CNT_W = 8
`ifdef RESULT_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 200
`endif
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             req_in,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   output logic [WIDTH-1:0] out_data,
   output logic [LAT_W-1:0] out_lat,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic             busy,
   output logic             stray,
   output logic             timeout
);

   state_t             state_q, state_d;
   logic [LAT_W-1:0]   lat;
   logic [LAT_W-1:0]   lat_plus1;
   logic               lat_clr;
   logic               lat_inc;

   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic [LAT_W-1:0]   out_lat_q,   out_lat_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               stray_q,     stray_d;
   logic               timeout_q,   timeout_d;

   // Cycles elapsed since the request; lat counts WAIT cycles minus one.
   algorithm_result_sink_sat_counter #(
      .W (LAT_W)
   ) u_lat (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (lat_clr),
      .inc   (lat_inc),
      .value (lat)
   );

   // Next-state, counter control and status update for the handshake FSM.
   always_comb begin
      state_d     = state_q;
      lat_clr     = 1'b0;
      lat_inc     = 1'b0;
      out_data_d  = out_data_q;
      out_lat_d   = out_lat_q;
      out_valid_d = 1'b0;
      out_count_d = out_count_q;
      stray_d     = stray_q;
      timeout_d   = timeout_q;
      // Reported latency includes the capture cycle itself, saturating.
      lat_plus1   = (lat == {LAT_W{1'b1}}) ? lat : lat + 1'b1;

      case (state_q)
         ST_IDLE: begin
            // A result with no request outstanding is recorded but flagged.
            if (res_valid) begin
               out_data_d = res_data;
               out_lat_d  = '0;
               stray_d    = 1'b1;
            end
            if (req_in) begin
               state_d = ST_WAIT;
               lat_clr = 1'b1;
            end
         end
         ST_WAIT: begin
            if (res_valid) begin
               out_data_d  = res_data;
               out_lat_d   = lat_plus1;
               out_valid_d = 1'b1;
               out_count_d = out_count_q + 1'b1;
               state_d     = ST_IDLE;
            end
            // A new request restarts the measurement, even after a capture.
            if (req_in) begin
               state_d = ST_WAIT;
               lat_clr = 1'b1;
            end else if (!res_valid) begin
               lat_inc = 1'b1;
`ifdef RESULT_TIMEOUT_EN
               if (lat == LAT_W'(TIMEOUT - 1)) begin
                  state_d   = ST_IDLE;
                  timeout_d = 1'b1;
                  lat_inc   = 1'b0;
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and status registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         out_data_q  <= '0;
         out_lat_q   <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         stray_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_lat_q   <= out_lat_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         stray_q     <= stray_d;
         timeout_q   <= timeout_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_lat   = out_lat_q;
   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign busy      = (state_q == ST_WAIT);
   assign stray     = stray_q;
   assign timeout   = timeout_q;

endmodule : algorithm_result_sink

`default_nettype wire

// File: tb/tb_algorithm_result_sink.sv
// ============================================================================
// Module : tb_algorithm_result_sink
// Brief  : Self-checking bench for algorithm_result_sink with a cycle-count
//          reference model (latency = capture cycle - request cycle).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_algorithm_result_sink;

   localparam int WIDTH = 8;
   localparam int LAT_W = 4;
   localparam int CNT_W = 4;
`ifdef RESULT_TIMEOUT_EN
   localparam int TMO   = 10;
`endif

   logic             clk       = 1'b0;
   logic             nrst      = 1'b0;
   logic             req_in    = 1'b0;
   logic             res_valid = 1'b0;
   logic [WIDTH-1:0] res_data  = '0;
   logic [WIDTH-1:0] out_data;
   logic [LAT_W-1:0] out_lat;
   logic             out_valid;
   logic [CNT_W-1:0] out_count;
   logic             busy;
   logic             stray;
   logic             timeout;

   always #5 clk = ~clk;

   algorithm_result_sink #(
      .WIDTH (WIDTH),
      .LAT_W (LAT_W),
      .CNT_W (CNT_W)
`ifdef RESULT_TIMEOUT_EN
      ,
      .TIMEOUT (TMO)
`endif
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_in    (req_in),
      .res_valid (res_valid),
      .res_data  (res_data),
      .out_data  (out_data),
      .out_lat   (out_lat),
      .out_valid (out_valid),
      .out_count (out_count),
      .busy      (busy),
      .stray     (stray),
      .timeout   (timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [WIDTH-1:0] m_data    = '0;
   logic [LAT_W-1:0] m_lat     = '0;
   logic             m_valid   = 1'b0;
   logic [CNT_W-1:0] m_count   = '0;
   logic             m_busy    = 1'b0;
   logic             m_stray   = 1'b0;
   logic             m_timeout = 1'b0;
   int               cyc       = 0;
   int               t_req     = 0;

   // Drive one cycle of inputs, advance the model, settle 1 time unit after the edge.
   task automatic cycle(input logic rst_n, input logic req, input logic rv,
                        input logic [WIDTH-1:0] d);
      int k;
      nrst      = rst_n;
      req_in    = req;
      res_valid = rv;
      res_data  = d;
      @(posedge clk);
      cyc++;
      m_valid = 1'b0;
      if (!rst_n) begin
         m_data = '0; m_lat = '0; m_count = '0;
         m_busy = 1'b0; m_stray = 1'b0; m_timeout = 1'b0;
      end else if (!m_busy) begin
         if (rv) begin
            m_data  = d;
            m_lat   = '0;
            m_stray = 1'b1;
         end
         if (req) begin
            m_busy = 1'b1;
            t_req  = cyc;
         end
      end else begin
         k = cyc - t_req;
         if (rv) begin
            m_data  = d;
            m_lat   = (k > 15) ? 4'd15 : 4'(k);
            m_valid = 1'b1;
            m_count = m_count + 1'b1;
         end
         if (req) t_req = cyc;
         else if (rv) m_busy = 1'b0;
`ifdef RESULT_TIMEOUT_EN
         else if (k == TMO) begin
            m_busy    = 1'b0;
            m_timeout = 1'b1;
         end
`endif
      end
      #1;
   endtask

   task automatic test_reset;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'hFF);
      n_checks++;
      if ({out_data, out_lat, out_valid, out_count, busy, stray, timeout} !== 20'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h want 00000",
                  {out_data, out_lat, out_valid, out_count, busy, stray, timeout});
      end
   endtask

   task automatic test_basic;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++; $display("FAIL basic_busy_wait: got %b want 1", busy);
      end
      cycle(1'b1, 1'b0, 1'b1, 8'h06);
      n_checks++;
      if ({out_valid, out_data, out_lat, out_count, busy} !== {1'b1, 8'h06, 4'd5, 4'd1, 1'b0}) begin
         n_errors++;
         $display("FAIL basic_capture: got v=%b d=%h lat=%0d cnt=%0d busy=%b want v=1 d=06 lat=5 cnt=1 busy=0",
                  out_valid, out_data, out_lat, out_count, busy);
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++; $display("FAIL basic_pulse_width: got %b want 0", out_valid);
      end
   endtask

   task automatic test_stray;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h11);
      n_checks++;
      if ({stray, out_data, out_lat, out_valid, out_count} !== {1'b1, 8'h11, 4'd0, 1'b0, 4'd0}) begin
         n_errors++;
         $display("FAIL stray_idle: got s=%b d=%h lat=%0d v=%b cnt=%0d want s=1 d=11 lat=0 v=0 cnt=0",
                  stray, out_data, out_lat, out_valid, out_count);
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({out_valid, stray} !== 2'b01) begin
         n_errors++; $display("FAIL stray_sticky: got v=%b s=%b want v=0 s=1", out_valid, stray);
      end
   endtask

   task automatic test_restart;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b1, 8'h02);
      n_checks++;
      if ({out_valid, out_data, out_lat, out_count, busy} !== {1'b1, 8'h02, 4'd3, 4'd1, 1'b1}) begin
         n_errors++;
         $display("FAIL restart_capture: got v=%b d=%h lat=%0d cnt=%0d busy=%b want v=1 d=02 lat=3 cnt=1 busy=1",
                  out_valid, out_data, out_lat, out_count, busy);
      end
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h5A);
      n_checks++;
      if ({out_valid, out_data, out_lat, out_count, busy} !== {1'b1, 8'h5A, 4'd4, 4'd2, 1'b0}) begin
         n_errors++;
         $display("FAIL restart_second: got v=%b d=%h lat=%0d cnt=%0d busy=%b want v=1 d=5a lat=4 cnt=2 busy=0",
                  out_valid, out_data, out_lat, out_count, busy);
      end
   endtask

   task automatic test_saturate;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (39) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h77);
      n_checks++;
      if ({out_valid, out_lat, out_data} !== {1'b1, 4'd15, 8'h77}) begin
         n_errors++;
         $display("FAIL saturate_lat: got v=%b lat=%0d d=%h want v=1 lat=15 d=77",
                  out_valid, out_lat, out_data);
      end
   endtask

`ifdef RESULT_TIMEOUT_EN
   task automatic test_timeout;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (TMO - 1) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({busy, timeout} !== 2'b10) begin
         n_errors++; $display("FAIL timeout_early: got busy=%b to=%b want busy=1 to=0", busy, timeout);
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({busy, timeout, out_valid, out_count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
         n_errors++;
         $display("FAIL timeout_abort: got busy=%b to=%b v=%b cnt=%0d want busy=0 to=1 v=0 cnt=0",
                  busy, timeout, out_valid, out_count);
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h33);
      n_checks++;
      if ({stray, out_valid, out_data, timeout} !== {1'b1, 1'b0, 8'h33, 1'b1}) begin
         n_errors++;
         $display("FAIL timeout_late_stray: got s=%b v=%b d=%h to=%b want s=1 v=0 d=33 to=1",
                  stray, out_valid, out_data, timeout);
      end
   endtask
`endif

   task automatic test_reset_mid_wait;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b1, 8'h44);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'hAA);
      n_checks++;
      if ({out_data, out_lat, out_valid, out_count, busy, stray, timeout} !== 20'h0) begin
         n_errors++;
         $display("FAIL reset_mid_wait: got %h want 00000",
                  {out_data, out_lat, out_valid, out_count, busy, stray, timeout});
      end
      cycle(1'b1, 1'b0, 1'b1, 8'h21);
      n_checks++;
      if ({stray, out_valid, out_data, out_count} !== {1'b1, 1'b0, 8'h21, 4'd0}) begin
         n_errors++;
         $display("FAIL reset_then_stray: got s=%b v=%b d=%h cnt=%0d want s=1 v=0 d=21 cnt=0",
                  stray, out_valid, out_data, out_count);
      end
   endtask

   task automatic test_random;
      logic r, q, v;
      logic [WIDTH-1:0] d;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 299) != 0);
         q = ($urandom_range(0, 7) == 0);
         v = ($urandom_range(0, 5) == 0);
         d = WIDTH'($urandom);
         cycle(r, q, v, d);
         n_checks++;
         if ({out_data, out_lat, out_valid, out_count, busy, stray, timeout} !==
             {m_data, m_lat, m_valid, m_count, m_busy, m_stray, m_timeout}) begin
            n_errors++;
            $display("FAIL random_cycle_%0d: got d=%h lat=%0d v=%b cnt=%0d busy=%b s=%b to=%b want d=%h lat=%0d v=%b cnt=%0d busy=%b s=%b to=%b",
                     cyc, out_data, out_lat, out_valid, out_count, busy, stray, timeout,
                     m_data, m_lat, m_valid, m_count, m_busy, m_stray, m_timeout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stray();
      test_restart();
      test_saturate();
`ifdef RESULT_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_algorithm_result_sink

`default_nettype wire
